// File: rtl/bus_width_pkg.sv
// Shared definitions for the bus width adapter family (decrease and increase).
// The state enum is common so both adapters report occupancy the same way.
package bus_width_pkg;

  // Occupancy of an adapter: nothing held, one word held, two words held
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } bw_state_t;

  // Width of a slice pointer addressing n slices; never narrower than one bit
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_width_decrease.sv
// Wide-to-narrow bus adapter: accepts one SIZE_IN word and emits it as
// SIZE_IN/SIZE_OUT slices over a ready/valid handshake, least- or
// most-significant slice first depending on LITTLE_ENDIAN.
//
// Optional build macro BUS_WIDTH_DECREASE_PREFETCH_EN adds a second holding
// register so the next word can be taken while the current one drains,
// giving gapless output. Without it one idle output cycle separates words.
module bus_width_decrease
  import bus_width_pkg::*;
#(
  parameter int SIZE_IN       = 32,
  parameter int SIZE_OUT      = 8,
  parameter int LITTLE_ENDIAN = 1
) (
  input  logic                clk,
  input  logic                reset,
  output logic                input_ready,
  input  logic                input_valid,
  input  logic [SIZE_IN-1:0]  input_data,
  input  logic                output_ready,
  output logic                output_valid,
  output logic [SIZE_OUT-1:0] output_data,
  output logic                output_last
);

  localparam int N     = SIZE_IN / SIZE_OUT;
  localparam int PTR_W = ptr_width(N);

  // Slice order: first and final slice index depend on endianness
  localparam logic [PTR_W-1:0] FIRST_IDX = (LITTLE_ENDIAN != 0) ? PTR_W'(0)   : PTR_W'(N-1);
  localparam logic [PTR_W-1:0] LAST_IDX  = (LITTLE_ENDIAN != 0) ? PTR_W'(N-1) : PTR_W'(0);

  // A wide word that does not split into whole slices is a configuration bug
  generate
    if ((SIZE_IN % SIZE_OUT) != 0) begin : g_bad_ratio
      $error("bus_width_decrease: SIZE_IN must be a multiple of SIZE_OUT");
    end
  endgenerate

  bw_state_t          state;
  logic [SIZE_IN-1:0] holding;
  logic [PTR_W-1:0]   ptr;

`ifdef BUS_WIDTH_DECREASE_PREFETCH_EN
  logic [SIZE_IN-1:0] holding_next;
`endif

  logic in_fire;
  logic out_fire;
  logic at_last;
  logic final_fire;

  assign in_fire    = input_valid && input_ready;
  assign out_fire   = output_valid && output_ready;
  assign at_last    = (ptr == LAST_IDX);
  assign final_fire = out_fire && at_last;

  // Slice and last flag are pure decodes of registers, so they cannot
  // change while the consumer stalls
  assign output_data = holding[ptr*SIZE_OUT +: SIZE_OUT];
  assign output_last = output_valid && at_last;

  // Slice pointer steps only when a slice is actually taken, wrapping
  // back to the first slice after the final one
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= FIRST_IDX;
    end else if (out_fire) begin
      if (at_last) begin
        ptr <= FIRST_IDX;
      end else if (LITTLE_ENDIAN != 0) begin
        ptr <= ptr + PTR_W'(1);
      end else begin
        ptr <= ptr - PTR_W'(1);
      end
    end
  end

  // Occupancy FSM with registered handshake outputs and word capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= EMPTY;
      input_ready  <= 1'b1;
      output_valid <= 1'b0;
      holding      <= '0;
`ifdef BUS_WIDTH_DECREASE_PREFETCH_EN
      holding_next <= '0;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            holding      <= input_data;
            state        <= BUSY;
            output_valid <= 1'b1;
`ifdef BUS_WIDTH_DECREASE_PREFETCH_EN
            input_ready  <= 1'b1;
`else
            input_ready  <= 1'b0;
`endif
          end
        end

        BUSY: begin
`ifdef BUS_WIDTH_DECREASE_PREFETCH_EN
          if (in_fire && final_fire) begin
            holding      <= input_data;
          end else if (in_fire) begin
            holding_next <= input_data;
            state        <= FULL;
            input_ready  <= 1'b0;
          end else if (final_fire) begin
            state        <= EMPTY;
            output_valid <= 1'b0;
          end
`else
          if (final_fire) begin
            state        <= EMPTY;
            input_ready  <= 1'b1;
            output_valid <= 1'b0;
          end
`endif
        end

`ifdef BUS_WIDTH_DECREASE_PREFETCH_EN
        FULL: begin
          if (final_fire) begin
            holding     <= holding_next;
            state       <= BUSY;
            input_ready <= 1'b1;
          end
        end
`endif

        default: begin
          state        <= EMPTY;
          input_ready  <= 1'b1;
          output_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_width_decrease.sv
// Self-checking bench for bus_width_decrease. Two instances (LE and BE) share
// one stimulus stream; a word-level model predicts handshakes and slices.
module tb_bus_width_decrease;

  localparam int SIZE_IN  = 32;
  localparam int SIZE_OUT = 8;
  localparam int N        = SIZE_IN / SIZE_OUT;

  logic                clk = 1'b0;
  logic                reset;
  logic                input_valid;
  logic [SIZE_IN-1:0]  input_data;
  logic                output_ready;

  logic                le_input_ready, le_output_valid, le_output_last;
  logic [SIZE_OUT-1:0] le_output_data;
  logic                be_input_ready, be_output_valid, be_output_last;
  logic [SIZE_OUT-1:0] be_output_data;

  int checks = 0;
  int errors = 0;

  // Model: words held by the adapter, slices already taken from the oldest
  logic [SIZE_IN-1:0] words[$];
  int                 slice_k = 0;
  int                 held = 0;
  logic [SIZE_IN-1:0] tx[$];

  bus_width_decrease #(.SIZE_IN(SIZE_IN), .SIZE_OUT(SIZE_OUT), .LITTLE_ENDIAN(1)) dut_le (
    .clk(clk), .reset(reset),
    .input_ready(le_input_ready), .input_valid(input_valid), .input_data(input_data),
    .output_ready(output_ready), .output_valid(le_output_valid),
    .output_data(le_output_data), .output_last(le_output_last)
  );

  bus_width_decrease #(.SIZE_IN(SIZE_IN), .SIZE_OUT(SIZE_OUT), .LITTLE_ENDIAN(0)) dut_be (
    .clk(clk), .reset(reset),
    .input_ready(be_input_ready), .input_valid(input_valid), .input_data(input_data),
    .output_ready(output_ready), .output_valid(be_output_valid),
    .output_data(be_output_data), .output_last(be_output_last)
  );

  always #5 clk = ~clk;

  function automatic logic model_ready();
`ifdef BUS_WIDTH_DECREASE_PREFETCH_EN
    return held < 2;
`else
    return held == 0;
`endif
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare both instances with what the model expects for this cycle
  task automatic checkOutput();
    logic               exp_valid, exp_last;
    logic [SIZE_IN-1:0] w;
    logic [7:0]         exp_le, exp_be;
    exp_valid = (held > 0);
    exp_last  = exp_valid && (slice_k == N - 1);
    checkEq("le_input_ready", 32'(le_input_ready), 32'(model_ready()));
    checkEq("be_input_ready", 32'(be_input_ready), 32'(model_ready()));
    checkEq("le_output_valid", 32'(le_output_valid), 32'(exp_valid));
    checkEq("be_output_valid", 32'(be_output_valid), 32'(exp_valid));
    checkEq("le_output_last", 32'(le_output_last), 32'(exp_last));
    checkEq("be_output_last", 32'(be_output_last), 32'(exp_last));
    if (exp_valid) begin
      w      = words[0];
      exp_le = w[slice_k*8 +: 8];
      exp_be = w[(N-1-slice_k)*8 +: 8];
      checkEq("le_output_data", 32'(le_output_data), 32'(exp_le));
      checkEq("be_output_data", 32'(be_output_data), 32'(exp_be));
    end
  endtask

  // One clock cycle: drive inputs, check outputs, then advance the model
  task automatic applyStimulus(input logic v, input logic [SIZE_IN-1:0] d, input logic r,
                               output logic accepted);
    logic in_fire, out_fire;
    @(negedge clk);
    input_valid  = v;
    input_data   = d;
    output_ready = r;
    checkOutput();
    in_fire  = v && model_ready();
    out_fire = r && (held > 0);
    @(posedge clk);
    if (out_fire) begin
      slice_k++;
      if (slice_k == N) begin
        slice_k = 0;
        void'(words.pop_front());
        held--;
      end
    end
    if (in_fire) begin
      words.push_back(d);
      held++;
    end
    accepted = in_fire;
  endtask

  // Offer the next pending word (if any and if v) for one cycle
  task automatic runCycle(input logic v, input logic r);
    logic acc;
    logic offer;
    offer = v && (tx.size() > 0);
    applyStimulus(offer, offer ? tx[0] : SIZE_IN'($urandom), r, acc);
    if (acc) void'(tx.pop_front());
  endtask

  task automatic doReset();
    @(negedge clk);
    reset        = 1'b1;
    input_valid  = 1'b0;
    output_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    words.delete();
    tx.delete();
    held    = 0;
    slice_k = 0;
    checkEq("rst_le_input_ready", 32'(le_input_ready), 32'd1);
    checkEq("rst_be_input_ready", 32'(be_input_ready), 32'd1);
    checkEq("rst_le_output_valid", 32'(le_output_valid), 32'd0);
    checkEq("rst_be_output_valid", 32'(be_output_valid), 32'd0);
    checkEq("rst_le_output_last", 32'(le_output_last), 32'd0);
    checkEq("rst_be_output_last", 32'(be_output_last), 32'd0);
    checkEq("rst_le_output_data", 32'(le_output_data), 32'd0);
    checkEq("rst_be_output_data", 32'(be_output_data), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    input_valid  = 1'b0;
    input_data   = '0;
    output_ready = 1'b0;

    // Reset state
    doReset();

    // Single word streamed with output always ready
    tx.push_back(32'hDDCCBBAA);
    for (int i = 0; i < 6; i++) runCycle(1'b1, 1'b1);

    // Stall for three cycles on the second slice
    tx.push_back(32'hDDCCBBAA);
    runCycle(1'b1, 1'b1);
    runCycle(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) runCycle(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) runCycle(1'b1, 1'b1);

    // Back-to-back words with input_valid held high
    tx.push_back(32'h44332211);
    tx.push_back(32'h88776655);
    for (int i = 0; i < 12; i++) runCycle(1'b1, 1'b1);

    // Reset after two slices; the next word restarts at the first slice
    tx.push_back(32'hDDCCBBAA);
    for (int i = 0; i < 3; i++) runCycle(1'b1, 1'b1);
    doReset();
    tx.push_back(32'h04030201);
    for (int i = 0; i < 6; i++) runCycle(1'b1, 1'b1);

    // Random traffic on both sides
    for (int i = 0; i < 400; i++) begin
      if (tx.size() < 2) tx.push_back(SIZE_IN'($urandom));
      runCycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    // Drain whatever is still held
    tx.delete();
    for (int i = 0; i < 12; i++) runCycle(1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_width_decrease.md
BUS_WIDTH_DECREASE -- requirements
Module: bus_width_decrease

Interface
REQ-001 SHALL have parameter SIZE_IN, default 32, meaning input (wide) bus width in bits.
REQ-002 SHALL have parameter SIZE_OUT, default 8, meaning output (narrow) bus width in bits.
REQ-003 SHALL have parameter LITTLE_ENDIAN, default 1, meaning 1 = least-significant slice emitted first, 0 = most-significant slice first.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port input_ready  output  1  block can accept a wide word this cycle.
REQ-007 SHALL have port input_valid  input  1  input_data is valid.
REQ-008 SHALL have port input_data  input  SIZE_IN  wide word.
REQ-009 SHALL have port output_ready  input  1  downstream accepts a slice this cycle.
REQ-010 SHALL have port output_valid  output  1  output_data holds a valid slice.
REQ-011 SHALL have port output_data  output  SIZE_OUT  current slice.
REQ-012 SHALL have port output_last  output  1  high with output_valid on the final slice of a word.

Function
REQ-013 SHALL define N = SIZE_IN/SIZE_OUT slices per word; elaboration error if SIZE_IN % SIZE_OUT != 0.
REQ-014 SHALL transfer on input only when input_valid && input_ready, and on output only when output_valid && output_ready.
REQ-015 SHALL register an accepted word into a holding register; first slice presented with output_valid=1 on the cycle after acceptance (latency 1).
REQ-016 SHALL select slice i as holding[i*SIZE_OUT +: SIZE_OUT], with i stepping 0..N-1 (LITTLE_ENDIAN=1) or N-1..0 (LITTLE_ENDIAN=0); slice pointer width max(1, clog2(N)).
REQ-017 SHALL advance the slice pointer only on an output transfer; output_data and output_last SHALL stay stable while output_valid && ~output_ready.
REQ-018 SHALL assert output_last exactly when the pointer equals the final slice index; on that transfer the pointer wraps to the first index.
REQ-019 SHALL implement state machine EMPTY (no word held, output_valid=0) and BUSY (word held, output_valid=1).
REQ-020 SHALL transition EMPTY->BUSY on an input transfer, BUSY->EMPTY on an output transfer with output_last=1, else hold state.
REQ-021 SHALL drive input_ready from registered state only (no combinational path from output_ready), input_ready=1 in EMPTY, 0 in BUSY (base build).
REQ-022 SHALL, for N=1, behave as a one-entry register stage with output_last=1 whenever output_valid=1.
REQ-023 SHALL never drop, duplicate or reorder slices or words.

Reset
REQ-024 SHALL on reset force state EMPTY, slice pointer to first index, holding registers to 0, and any queued word discarded.
REQ-025 SHALL drive after reset: input_ready=1, output_valid=0, output_last=0, output_data=0.
REQ-026 SHALL, on reset asserted mid-word, abandon remaining slices; the next accepted word starts at the first slice.

Configuration
REQ-027 SHALL support macro BUS_WIDTH_DECREASE_PREFETCH_EN.
REQ-028 SHALL, without the macro, sustain at most one word per N+1 cycles (one idle output cycle between words).
REQ-029 SHALL, with the macro, add a second holding register and state FULL (two words held): input_ready=1 in EMPTY and BUSY, 0 in FULL; BUSY->FULL on input transfer without final-slice output transfer; FULL->BUSY on final-slice output transfer; next word's first slice presented the cycle after the previous word's last slice transfer (gapless, one word per N cycles at output_ready=1).
REQ-030 SHALL keep input_ready registered-only in both builds.

Structure
REQ-031 SHALL place the state enum (EMPTY, BUSY, FULL) in shared package bus_width_pkg, reused by the width-increase adapter family.
REQ-032 SHALL be a single module; no sub-module required.

Verification
REQ-033 SHALL test LE, 32->8, input 0xDDCCBBAA, output_ready=1: output AA,BB,CC,DD on 4 consecutive cycles, output_last only on DD.
REQ-034 SHALL test LITTLE_ENDIAN=0, same input: output DD,CC,BB,AA, output_last on AA.
REQ-035 SHALL test backpressure: output_ready=0 for 3 cycles at slice BB: output_data=BB, output_valid=1 held stable, no slice lost.
REQ-036 SHALL test back-to-back words 0x44332211, 0x88776655, input_valid=1: without macro 1-cycle gap between 44 and 55; with macro 8 consecutive slices 11..88, input_ready low only in FULL.
REQ-037 SHALL test reset after 2 slices of 0xDDCCBBAA: output_valid=0 next cycle; next word 0x04030201 emits 01 first.
